// File: rtl/acc_exec_pkg.sv
// rtl/acc_exec_pkg.sv - shared opcodes, FSM states and default widths for acc_exec_unit
package acc_exec_pkg;

    localparam int DW_DEF  = 8;
    localparam int PW_DEF  = 8;
    localparam int OPW_DEF = 4;

    localparam logic [3:0] OP_NOP = 4'h0;
    localparam logic [3:0] OP_LDI = 4'h1;
    localparam logic [3:0] OP_ADD = 4'h2;
    localparam logic [3:0] OP_SUB = 4'h3;
    localparam logic [3:0] OP_AND = 4'h4;
    localparam logic [3:0] OP_OR  = 4'h5;
    localparam logic [3:0] OP_XOR = 4'h6;
    localparam logic [3:0] OP_LDD = 4'h7;
    localparam logic [3:0] OP_JMP = 4'h8;
    localparam logic [3:0] OP_JZ  = 4'h9;
    localparam logic [3:0] OP_HLT = 4'hF;

    typedef enum logic [1:0] {
        S_WAIT_F = 2'd0,
        S_WAIT_E = 2'd1,
        S_WAIT_W = 2'd2
    } state_t;

endpackage

// File: rtl/acc_alu.sv
// rtl/acc_alu.sv - combinational ALU: result, carry/borrow and write-enables per opcode
module acc_alu
    import acc_exec_pkg::*;
#(
    parameter int DW  = DW_DEF,
    parameter int OPW = OPW_DEF
) (
    input  logic [OPW-1:0] opcode,
    input  logic [DW-1:0]  acc,
    input  logic [DW-1:0]  imm,
    input  logic [DW-1:0]  data_in,
    output logic [DW-1:0]  res,
    output logic           c,
    output logic           wr_acc,
    output logic           wr_z,
    output logic           wr_c
);

    always_comb begin
        res    = acc;
        c      = 1'b0;
        wr_acc = 1'b0;
        wr_z   = 1'b0;
        wr_c   = 1'b0;
        case (opcode)
            OPW'(OP_LDI): begin
                res    = imm;
                wr_acc = 1'b1;
                wr_z   = 1'b1;
            end
            OPW'(OP_ADD): begin
                {c, res} = {1'b0, acc} + {1'b0, imm};
                wr_acc   = 1'b1;
                wr_z     = 1'b1;
                wr_c     = 1'b1;
            end
            // The extra MSB of the widened difference is the borrow
            OPW'(OP_SUB): begin
                {c, res} = {1'b0, acc} - {1'b0, imm};
                wr_acc   = 1'b1;
                wr_z     = 1'b1;
                wr_c     = 1'b1;
            end
            OPW'(OP_AND): begin
                res    = acc & imm;
                wr_acc = 1'b1;
                wr_z   = 1'b1;
            end
            OPW'(OP_OR): begin
                res    = acc | imm;
                wr_acc = 1'b1;
                wr_z   = 1'b1;
            end
            OPW'(OP_XOR): begin
                res    = acc ^ imm;
                wr_acc = 1'b1;
                wr_z   = 1'b1;
            end
            OPW'(OP_LDD): begin
                res    = data_in;
                wr_acc = 1'b1;
                wr_z   = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/acc_exec_unit.sv
// rtl/acc_exec_unit.sv - accumulator execute stage; ACC_EXEC_RETIRE_CNT_EN adds the retired counter
module acc_exec_unit
    import acc_exec_pkg::*;
#(
    parameter int DW  = DW_DEF,
    parameter int PW  = PW_DEF,
    parameter int OPW = OPW_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ph_fetch,
    input  logic              ph_exec,
    input  logic              acc_write,
    input  logic [OPW+DW-1:0] instr,
    input  logic [DW-1:0]     data_in,
    output logic [PW-1:0]     pc_out,
    output logic [DW-1:0]     acc_out,
    output logic              zero,
    output logic              carry,
    output logic              halt,
`ifdef ACC_EXEC_RETIRE_CNT_EN
    output logic [15:0]       retired,
`endif
    output logic              seq_err
);

    localparam int IW = OPW + DW;

    state_t        state;
    logic [IW-1:0] ir;
    logic [DW-1:0] res_q;
    logic          c_q;

    logic [OPW-1:0] op;
    logic [DW-1:0]  imm;
    logic [DW-1:0]  alu_res;
    logic           alu_c;
    logic           wr_acc;
    logic           wr_z;
    logic           wr_c;

    logic fetch_s;
    logic exec_s;
    logic commit_s;
    logic any_s;
    logic jump_taken;

    assign op  = ir[IW-1:DW];
    assign imm = ir[DW-1:0];

    acc_alu #(
        .DW (DW),
        .OPW(OPW)
    ) u_alu (
        .opcode (op),
        .acc    (acc_out),
        .imm    (imm),
        .data_in(data_in),
        .res    (alu_res),
        .c      (alu_c),
        .wr_acc (wr_acc),
        .wr_z   (wr_z),
        .wr_c   (wr_c)
    );

    // Commit outranks everything; fetch+exec together decodes to none of the three
    assign commit_s   = acc_write;
    assign fetch_s    = ph_fetch & ~acc_write & ~ph_exec;
    assign exec_s     = ph_exec & ~ph_fetch & ~acc_write;
    assign any_s      = ph_fetch | ph_exec | acc_write;
    assign jump_taken = (op == OPW'(OP_JMP)) || ((op == OPW'(OP_JZ)) && zero);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= S_WAIT_F;
            ir      <= '0;
            res_q   <= '0;
            c_q     <= 1'b0;
            pc_out  <= '0;
            acc_out <= '0;
            zero    <= 1'b0;
            carry   <= 1'b0;
            halt    <= 1'b0;
            seq_err <= 1'b0;
`ifdef ACC_EXEC_RETIRE_CNT_EN
            retired <= '0;
`endif
        end else if (!halt && any_s) begin
            // Any unexpected strobe aborts the frame back to the fetch wait
            state <= S_WAIT_F;
            case (state)
                S_WAIT_F: begin
                    if (fetch_s) begin
                        ir    <= instr;
                        state <= S_WAIT_E;
                    end else begin
                        seq_err <= 1'b1;
                    end
                end
                S_WAIT_E: begin
                    if (exec_s) begin
                        res_q <= alu_res;
                        c_q   <= alu_c;
                        state <= S_WAIT_W;
                    end else begin
                        seq_err <= 1'b1;
                    end
                end
                S_WAIT_W: begin
                    if (commit_s) begin
                        if (wr_acc) acc_out <= res_q;
                        if (wr_z)   zero    <= (res_q == '0);
                        if (wr_c)   carry   <= c_q;
                        if (op == OPW'(OP_HLT))
                            halt <= 1'b1;
                        else if (jump_taken)
                            pc_out <= PW'(imm);
                        else
                            pc_out <= pc_out + PW'(1);
`ifdef ACC_EXEC_RETIRE_CNT_EN
                        retired <= retired + 16'd1;
`endif
                    end else begin
                        seq_err <= 1'b1;
                    end
                end
                default: seq_err <= 1'b1;
            endcase
        end
    end

endmodule

// File: tb/tb_acc_exec_unit.sv
// tb/tb_acc_exec_unit.sv - directed and randomized bench for acc_exec_unit against a behavioural model
module tb_acc_exec_unit;

    logic        clk;
    logic        rst;
    logic        ph_fetch;
    logic        ph_exec;
    logic        acc_write;
    logic [11:0] instr;
    logic [7:0]  data_in;
    logic [7:0]  pc_out;
    logic [7:0]  acc_out;
    logic        zero;
    logic        carry;
    logic        halt;
    logic        seq_err;
`ifdef ACC_EXEC_RETIRE_CNT_EN
    logic [15:0] retired;
`endif

    acc_exec_unit dut (
        .clk      (clk),
        .rst      (rst),
        .ph_fetch (ph_fetch),
        .ph_exec  (ph_exec),
        .acc_write(acc_write),
        .instr    (instr),
        .data_in  (data_in),
        .pc_out   (pc_out),
        .acc_out  (acc_out),
        .zero     (zero),
        .carry    (carry),
        .halt     (halt),
`ifdef ACC_EXEC_RETIRE_CNT_EN
        .retired  (retired),
`endif
        .seq_err  (seq_err)
    );

    always #5 clk = ~clk;

    int n_chk;
    int n_pass;

    int m_acc, m_pc, m_z, m_c, m_halt, m_err, m_ret;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic model_reset();
        m_acc = 0; m_pc = 0; m_z = 0; m_c = 0; m_halt = 0; m_err = 0; m_ret = 0;
    endtask

    // Architectural effect of one legally committed instruction
    task automatic model_commit(input logic [11:0] iw, input logic [7:0] din);
        int op, imm, s;
        op  = int'(iw[11:8]);
        imm = int'(iw[7:0]);
        if (m_halt != 0) return;
        m_ret = (m_ret + 1) % 65536;
        case (op)
            1: m_acc = imm;
            2: begin s = m_acc + imm; m_c = (s > 255); m_acc = s % 256; end
            3: begin m_c = (imm > m_acc); m_acc = (m_acc - imm + 256) % 256; end
            4: m_acc = m_acc & imm;
            5: m_acc = m_acc | imm;
            6: m_acc = m_acc ^ imm;
            7: m_acc = int'(din);
            default: ;
        endcase
        if (op >= 1 && op <= 7) m_z = (m_acc == 0);
        if (op == 15)                  m_halt = 1;
        else if (op == 8)              m_pc = imm;
        else if (op == 9 && m_z != 0)  m_pc = imm;
        else                           m_pc = (m_pc + 1) % 256;
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".acc"},   acc_out, m_acc);
        chk({tag, ".pc"},    pc_out,  m_pc);
        chk({tag, ".zero"},  zero,    m_z);
        chk({tag, ".carry"}, carry,   m_c);
        chk({tag, ".halt"},  halt,    m_halt);
        chk({tag, ".err"},   seq_err, m_err);
`ifdef ACC_EXEC_RETIRE_CNT_EN
        chk({tag, ".ret"},   retired, m_ret);
`endif
    endtask

    task automatic cyc(input logic f, input logic e, input logic w);
        ph_fetch  = f;
        ph_exec   = e;
        acc_write = w;
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        ph_fetch = 0; ph_exec = 0; acc_write = 0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        model_reset();
    endtask

    // Generator frame: fetch, exec, fetch+commit, idle; instr/data_in perturbed outside their sample edges
    task automatic frame(input logic [11:0] iw, input logic [7:0] din);
        instr = iw;
        data_in = 8'($urandom);
        cyc(1, 0, 0);
        instr = 12'($urandom);
        data_in = din;
        cyc(0, 1, 0);
        data_in = 8'($urandom);
        cyc(1, 0, 1);
        cyc(0, 0, 0);
        model_commit(iw, din);
    endtask

    task automatic inject(input logic f, input logic e, input logic w);
        cyc(f, e, w);
        cyc(0, 0, 0);
        if (m_halt == 0) m_err = 1;
    endtask

    // Commit slot arrives as a bare fetch, so the frame aborts without retiring
    task automatic abort_frame(input logic [11:0] iw);
        instr = iw;
        cyc(1, 0, 0);
        cyc(0, 1, 0);
        cyc(1, 0, 0);
        cyc(0, 0, 0);
        if (m_halt == 0) m_err = 1;
    endtask

    initial begin
        clk = 0; rst = 0;
        ph_fetch = 0; ph_exec = 0; acc_write = 0;
        instr = '0; data_in = '0;
        n_chk = 0; n_pass = 0;
        model_reset();
        @(negedge clk);
        do_reset();
        check_all("reset");

        frame(12'h105, 8'h00);
        check_all("ldi05");
        chk("ldi05_acc_const", acc_out, 8'h05);
        chk("ldi05_pc_const", pc_out, 8'h01);

        frame(12'h1F0, 8'h00);
        frame(12'h220, 8'h00);
        check_all("add_carry");
        chk("add_acc_const", acc_out, 8'h10);
        chk("add_c_const", carry, 1'b1);
        frame(12'h310, 8'h00);
        check_all("sub_zero");
        chk("sub_z_const", zero, 1'b1);
        chk("sub_c_const", carry, 1'b0);

        frame(12'h940, 8'h00);
        check_all("jz_taken");
        chk("jz_taken_pc_const", pc_out, 8'h40);
        frame(12'h101, 8'h00);
        frame(12'h840, 8'h00);
        frame(12'h940, 8'h00);
        check_all("jz_not_taken");
        chk("jz_nt_pc_const", pc_out, 8'h41);
        frame(12'h8FF, 8'h00);
        frame(12'h000, 8'h00);
        check_all("pc_wrap");
        chk("pc_wrap_const", pc_out, 8'h00);

        frame(12'h7AA, 8'h3C);
        check_all("ldd");
        frame(12'h40F, 8'h00);
        frame(12'h5C0, 8'h00);
        frame(12'h6FF, 8'h00);
        check_all("logic_ops");

        inject(0, 1, 0);
        check_all("err_exec_in_f");
        chk("err_const", seq_err, 1'b1);
        frame(12'h133, 8'h00);
        check_all("after_err");

        do_reset();
        inject(1, 1, 0);
        check_all("err_illegal");
        do_reset();
        frame(12'h111, 8'h00);
        inject(0, 0, 1);
        check_all("err_commit_in_f");

        do_reset();
        instr = 12'h177;
        cyc(1, 0, 0);
        cyc(0, 1, 0);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        model_reset();
        check_all("midframe_rst");
        frame(12'h109, 8'h00);
        check_all("after_midframe_rst");

        do_reset();
        for (int i = 0; i < 60; i++) begin
            logic [11:0] iw;
            iw = {4'($urandom_range(0, 14)), 8'($urandom)};
            if ($urandom_range(0, 9) == 0) abort_frame(iw);
            else frame(iw, 8'($urandom));
            check_all($sformatf("rand%0d", i));
        end

        do_reset();
        frame(12'h112, 8'h00);
        frame(12'hF00, 8'h00);
        check_all("hlt");
        chk("hlt_pc_const", pc_out, 8'h01);
        for (int i = 0; i < 10; i++) frame(12'h1AA, 8'h00);
        inject(0, 1, 0);
        check_all("halted");
        chk("halted_acc_const", acc_out, 8'h12);
        rst = 1'b0;
        #1;
        model_reset();
        check_all("hlt_rst");
        @(negedge clk);
        rst = 1'b1;

`ifdef ACC_EXEC_RETIRE_CNT_EN
        do_reset();
        for (int i = 0; i < 5; i++) frame({4'($urandom_range(0, 7)), 8'($urandom)}, 8'($urandom));
        abort_frame(12'h155);
        check_all("retire5");
        chk("retire5_const", retired, 16'd5);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
